// File: rtl/com_pkg.sv
// ---------------------------------------------------------------------------
// com_pkg
// Shared definitions for the centroid frame controller: coordinate and
// counter widths, default active-area size, and the controller state type.
// ---------------------------------------------------------------------------
package com_pkg;

    localparam int X_W          = 11;    // pixel x width
    localparam int Y_W          = 10;    // pixel y width
    localparam int CNT_W        = 20;    // per-frame hit counter width
    localparam int H_ACTIVE_DEF = 1024;  // default active pixels per line
    localparam int V_ACTIVE_DEF = 768;   // default active lines per frame

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACCUM,
        S_TAB,
        S_WAIT,
        S_DONE
    } state_t;

endpackage

// File: rtl/com_frame_controller.sv
// ---------------------------------------------------------------------------
// com_frame_controller
// Sequences one centroid measurement per video frame around an external
// center_of_mass block: forwards masked in-area pixels during the frame,
// requests a tabulation after the last pixel, waits (bounded) for the result
// and publishes it as a latched centroid with a one-cycle valid pulse.
//
// Ports
//   clk_in, rst_in        clock, synchronous active-high reset
//   enable_in             level, allows a new frame to start
//   new_frame_in          pulse at frame start
//   hcount_in, vcount_in  current pixel coordinates
//   pixel_hit_in          current pixel passes the mask
//   com_x_out, com_y_out  pixel coordinates to center_of_mass
//   com_valid_out         pixel strobe to center_of_mass
//   com_tabulate_out      tabulate request pulse to center_of_mass
//   com_x_in, com_y_in    centroid from center_of_mass
//   com_valid_in          centroid strobe from center_of_mass
//   x_out, y_out          latched centroid
//   valid_out             pulse: frame result is final
//   found_out             level: last finished frame had at least one hit
//   timeout_out           pulse: result wait expired
//   skip_out              pulse: new_frame_in ignored while busy
// ---------------------------------------------------------------------------
module com_frame_controller
    import com_pkg::*;
#(
    parameter int H_ACTIVE       = H_ACTIVE_DEF,
    parameter int V_ACTIVE       = V_ACTIVE_DEF,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           enable_in,
    input  logic           new_frame_in,
    input  logic [X_W-1:0] hcount_in,
    input  logic [Y_W-1:0] vcount_in,
    input  logic           pixel_hit_in,
    output logic [X_W-1:0] com_x_out,
    output logic [Y_W-1:0] com_y_out,
    output logic           com_valid_out,
    output logic           com_tabulate_out,
    input  logic [X_W-1:0] com_x_in,
    input  logic [Y_W-1:0] com_y_in,
    input  logic           com_valid_in,
    output logic [X_W-1:0] x_out,
    output logic [Y_W-1:0] y_out,
    output logic           valid_out,
    output logic           found_out,
    output logic           timeout_out,
    output logic           skip_out
);

    localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);

    // Last in-area coordinates; "coord < ACTIVE" is evaluated as
    // "coord <= LAST" so the compare stays at the port width.
    localparam logic [X_W-1:0]    H_LAST    = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0]    V_LAST    = Y_W'(V_ACTIVE - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    state_t state, state_next;

    logic [CNT_W-1:0]  hit_cnt;
    logic [WAIT_W-1:0] wait_cnt;

    logic in_area;
    logic fwd;
    logic frame_end;
    logic any_hit;

    logic start;
    logic result_take;
    logic timeout_hit;
    logic empty_end;
    logic skip;

    assign in_area   = (hcount_in <= H_LAST) && (vcount_in <= V_LAST);
    assign fwd       = (state == S_ACCUM) && pixel_hit_in && in_area;
    assign frame_end = (state == S_ACCUM) && (hcount_in == H_LAST) && (vcount_in == V_LAST);
    // The final pixel is counted in the same cycle it ends the frame.
    assign any_hit   = (hit_cnt != '0) || fwd;

    // State register
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and one-cycle control decisions
    always_comb begin
        state_next  = state;
        start       = 1'b0;
        result_take = 1'b0;
        timeout_hit = 1'b0;
        empty_end   = 1'b0;
        skip        = new_frame_in && (state != S_IDLE);

        case (state)
            S_IDLE: begin
                if (new_frame_in && enable_in) begin
                    start      = 1'b1;
                    state_next = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (frame_end) begin
                    if (any_hit) begin
                        state_next = S_TAB;
                    end else begin
                        empty_end  = 1'b1;
                        state_next = S_DONE;
                    end
                end
            end
            S_TAB: begin
                state_next = S_WAIT;
            end
            S_WAIT: begin
                // A result arriving on the expiry cycle takes priority.
                if (com_valid_in) begin
                    result_take = 1'b1;
                    state_next  = S_DONE;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = S_IDLE;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Counters, center_of_mass interface and result registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hit_cnt          <= '0;
            wait_cnt         <= '0;
            com_x_out        <= '0;
            com_y_out        <= '0;
            com_valid_out    <= 1'b0;
            com_tabulate_out <= 1'b0;
            x_out            <= '0;
            y_out            <= '0;
            valid_out        <= 1'b0;
            found_out        <= 1'b0;
            timeout_out      <= 1'b0;
            skip_out         <= 1'b0;
        end else begin
            com_valid_out <= fwd;
            if (fwd) begin
                com_x_out <= hcount_in;
                com_y_out <= vcount_in;
            end

            // TAB follows the last possible pixel cycle, so registering the
            // request puts it one cycle after that pixel's com_valid_out.
            com_tabulate_out <= (state == S_TAB);

            if (start) begin
                hit_cnt <= '0;
            end else if (fwd && (hit_cnt != CNT_MAX)) begin
                hit_cnt <= hit_cnt + CNT_W'(1);
            end

            if (state == S_TAB) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end

            if (result_take) begin
                x_out     <= com_x_in;
                y_out     <= com_y_in;
                found_out <= 1'b1;
            end else if (empty_end) begin
                found_out <= 1'b0;
            end

            // DONE lasts one cycle, so this pulse coincides with DONE.
            valid_out   <= (state_next == S_DONE);
            timeout_out <= timeout_hit;
            skip_out    <= skip;
        end
    end

endmodule
